// File: rtl/snake_pkg.sv
// Shared constants for the board's serial receive path: FSM encoding and default baud timing.
package snake_pkg;

  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_FREQ / BAUD;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; resets to all ones (idle-high lines).
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, holds the last good byte, pulses on done / framing error.
module uart_rx_byte
  import snake_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullTerm = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfTerm = CntW'(HALF_BIT - 1);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            term;

  sync_2ff #(
    .Width(1)
  ) u_sync_rx (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    term    = (state_q == StStart) ? (cnt_q == HalfTerm) : (cnt_q == FullTerm);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (term) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (term) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in place after 8 samples.
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (term) begin
          cnt_d = '0;
          if (rx_s) begin
            done_d  = 1'b1;
            data_d  = shift_q;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    data_out  = data_q;
    rx_done   = done_q;
    frame_err = err_q;
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised self-checking bench for uart_rx_byte against an event-queue reference model.
module tb_uart_rx_byte;

  localparam int unsigned Cpb    = 16;
  localparam int unsigned LatNom = 2 + Cpb / 2 + 9 * Cpb + 1;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned t0;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int unsigned n_vec;
  int unsigned n_bad;
  int unsigned cyc;
  ev_t         exp_q[$];
  logic [7:0]  exp_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding frame; data_out must track the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done && frame_err) check("done_and_err", 1, 0);
      if (rx_done || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {31'd0, rx_done}, {31'd0, frame_err});
          check("unexpected_pulse_any", 1, 0);
        end else begin
          ev_t ev;
          int unsigned lat;
          ev  = exp_q.pop_front();
          lat = cyc - ev.t0;
          check("pulse_kind_err", {31'd0, frame_err}, {31'd0, ev.err});
          check("latency_in_window", (lat + 1 >= LatNom && lat <= LatNom + 1) ? 1 : 0, 1);
          if (!ev.err) exp_data = ev.data;
        end
      end
      check("data_out", {24'd0, data_out}, {24'd0, exp_data});
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop, input int rst_bit);
    ev_t ev;
    ev.err  = ~stop;
    ev.data = b;
    ev.t0   = cyc;
    exp_q.push_back(ev);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        repeat (Cpb / 2) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_data = 8'h00;
        #1;
        check("rst_data_out", {24'd0, data_out}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, rx_done}, 0);
        repeat (Cpb / 2) @(negedge clk);
      end else begin
        repeat (Cpb) @(negedge clk);
      end
    end
    rx = stop;
    repeat (Cpb) @(negedge clk);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    exp_data = 8'h00;
    rst      = 1'b1;
    rx       = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_data_out", {24'd0, data_out}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, rx_done}, 0);
    check("reset_err", {31'd0, frame_err}, 0);
    rst = 1'b0;

    repeat (500) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_data_out", {24'd0, data_out}, 0);

    send_frame(8'h34, 1'b1, -1);
    repeat (40) @(negedge clk);
    check("held_34", {24'd0, data_out}, 32'h34);

    send_frame(8'h38, 1'b1, -1);
    send_frame(8'h32, 1'b1, -1);
    repeat (40) @(negedge clk);
    check("b2b_last", {24'd0, data_out}, 32'h32);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 0);
    check("glitch_data", {24'd0, data_out}, 32'h32);

    send_frame(8'h36, 1'b0, -1);
    repeat (40) @(negedge clk);
    check("break_busy", {31'd0, busy}, 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_release_busy", {31'd0, busy}, 0);
    check("break_data", {24'd0, data_out}, 32'h32);
    repeat (20) @(negedge clk);

    // Reset is held through the rest of the 8'h39 frame so its tail is never framed.
    send_frame(8'h39, 1'b1, 4);
    check("rst_hold_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h35, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("after_rst_35", {24'd0, data_out}, 32'h35);

    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      bit stop;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, -1);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("final_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
